// File: rtl/imem_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : imem_dmem_arbiter
//  Description : Shares one valid/ready memory port between instruction fetch
//                and the load/store unit. Data has priority; a starvation
//                counter guarantees fetch progress. Routing is combinational,
//                and the grant is held while a granted request waits.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_dmem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    // fetch master
    input  logic                i_if_valid,
    input  logic [ADDR_W-1:0]   i_if_addr,
    output logic                o_if_ready,
    output logic [DATA_W-1:0]   o_if_rdata,
    // load/store master
    input  logic                i_d_valid,
    input  logic [ADDR_W-1:0]   i_d_addr,
    input  logic [DATA_W-1:0]   i_d_wdata,
    input  logic [DATA_W/8-1:0] i_d_wstrb,
    output logic                o_d_ready,
    output logic [DATA_W-1:0]   o_d_rdata,
    // memory port
    output logic                o_m_valid,
    output logic [ADDR_W-1:0]   o_m_addr,
    output logic [DATA_W-1:0]   o_m_wdata,
    output logic [DATA_W/8-1:0] o_m_wstrb,
    input  logic                i_s_ready,
    input  logic [DATA_W-1:0]   i_s_rdata,
    output logic [1:0]          o_grant
);

    localparam int c_STRB_W   = DATA_W / 8;
    localparam int c_STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_STARVE_W-1:0] c_LIMIT = c_STARVE_W'(STARVE_LIMIT);
    localparam logic [c_STARVE_W-1:0] c_ONE   = c_STARVE_W'(1);

    // Owner encoding doubles as the o_grant encoding.
    localparam logic [1:0] c_ST_NONE = 2'b00;
    localparam logic [1:0] c_ST_IF   = 2'b01;
    localparam logic [1:0] c_ST_DATA = 2'b10;

    logic [1:0]            r_owner;
    logic [1:0]            w_owner_nxt;
    logic [c_STARVE_W-1:0] r_starve;
    logic [c_STARVE_W-1:0] w_starve_nxt;

    logic [1:0]            w_sel;
    logic                  w_req;
    logic                  w_hs;
    logic [ADDR_W-1:0]     w_addr;
    logic [DATA_W-1:0]     w_wdata;
    logic [c_STRB_W-1:0]   w_wstrb;

    // Pick a master: re-arbitrate only when idle, otherwise keep the lock.
    always_comb begin
        w_sel = c_ST_NONE;
        if (r_owner == c_ST_NONE) begin
            if (i_d_valid && ((r_starve < c_LIMIT) || !i_if_valid)) begin
                w_sel = c_ST_DATA;
            end else if (i_if_valid) begin
                w_sel = c_ST_IF;
            end
        end else begin
            w_sel = r_owner;
        end
    end

    // Route the selected master onto the memory port; fetch never writes.
    always_comb begin
        w_req   = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        w_wstrb = '0;
        case (w_sel)
            c_ST_IF: begin
                w_req  = i_if_valid;
                w_addr = i_if_addr;
            end
            c_ST_DATA: begin
                w_req   = i_d_valid;
                w_addr  = i_d_addr;
                w_wdata = i_d_wdata;
                w_wstrb = i_d_wstrb;
            end
            default: ;
        endcase
    end

    assign w_hs = w_req & i_s_ready;

    // All outputs are forced quiet while reset is held.
    assign o_m_valid  = ~rst & w_req;
    assign o_m_addr   = rst ? '0 : w_addr;
    assign o_m_wdata  = rst ? '0 : w_wdata;
    assign o_m_wstrb  = rst ? '0 : w_wstrb;
    assign o_grant    = rst ? c_ST_NONE : w_sel;
    assign o_if_ready = ~rst & w_hs & (w_sel == c_ST_IF);
    assign o_d_ready  = ~rst & w_hs & (w_sel == c_ST_DATA);
    assign o_if_rdata = rst ? '0 : i_s_rdata;
    assign o_d_rdata  = rst ? '0 : i_s_rdata;

    // Lock a waiting request; release on completion or abandonment.
    always_comb begin
        w_owner_nxt = c_ST_NONE;
        if (w_req && !i_s_ready) begin
            w_owner_nxt = w_sel;
        end
    end

    // Count data wins while fetch waits; saturate at the limit.
    always_comb begin
        w_starve_nxt = r_starve;
        if (w_hs && (w_sel == c_ST_DATA) && i_if_valid) begin
            w_starve_nxt = (r_starve < c_LIMIT) ? (r_starve + c_ONE) : c_LIMIT;
        end else if ((w_hs && (w_sel == c_ST_IF)) || !i_if_valid) begin
            w_starve_nxt = '0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner  <= c_ST_NONE;
            r_starve <= '0;
        end else begin
            r_owner  <= w_owner_nxt;
            r_starve <= w_starve_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_dmem_arbiter
//  Description : Scoreboard bench for imem_dmem_arbiter. Random traffic is
//                scored against a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_dmem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LIMIT  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        d_valid;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        m_valid;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        s_ready;
    logic [31:0] s_rdata;
    logic [1:0]  grant;

    imem_dmem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .i_if_valid(if_valid), .i_if_addr(if_addr),
        .o_if_ready(if_ready), .o_if_rdata(if_rdata),
        .i_d_valid(d_valid), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
        .i_d_wstrb(d_wstrb), .o_d_ready(d_ready), .o_d_rdata(d_rdata),
        .o_m_valid(m_valid), .o_m_addr(m_addr), .o_m_wdata(m_wdata),
        .o_m_wstrb(m_wstrb), .i_s_ready(s_ready), .i_s_rdata(s_rdata),
        .o_grant(grant)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mv;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  grant;
        logic        ifr;
        logic        dr;
    } cyc_t;

    cyc_t        q_cyc[$];
    logic [31:0] q_if[$];
    logic [31:0] q_d[$];

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: who holds the port (0 none, 1 fetch, 2 data) and
    // how many data transfers have overtaken a waiting fetch.
    int m_holder = 0;
    int m_starve = 0;
    bit pend_if  = 0;
    bit pend_d   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // One cycle of stimulus; expected outputs go to the scoreboard.
    task automatic step(input bit r, input int p_if, input int p_d,
                        input int p_rdy, input int p_keep);
        cyc_t e;
        int   who;
        bit   req, f_done, d_done;
        @(posedge clk);
        #1;
        rst = r;
        if (pend_if && ($urandom_range(99) < p_keep)) if_valid = 1'b1;
        else begin
            if_valid = ($urandom_range(99) < p_if);
            if_addr  = {$urandom_range(32'h3FFF_FFFF), 2'b00};
        end
        if (pend_d && ($urandom_range(99) < p_keep)) d_valid = 1'b1;
        else begin
            d_valid = ($urandom_range(99) < p_d);
            d_addr  = $urandom;
            d_wdata = $urandom;
            d_wstrb = 4'($urandom_range(15));
        end
        s_ready = ($urandom_range(99) < p_rdy);
        s_rdata = $urandom;

        e = '{mv: 1'b0, addr: '0, wdata: '0, wstrb: '0, grant: 2'b00, ifr: 1'b0, dr: 1'b0};
        if (r) begin
            m_holder = 0;
            m_starve = 0;
            pend_if  = 0;
            pend_d   = 0;
        end else begin
            who = m_holder;
            if (who == 0) begin
                if (d_valid && (m_starve < LIMIT || !if_valid)) who = 2;
                else if (if_valid) who = 1;
            end
            req    = (who == 1) ? if_valid : (who == 2) ? d_valid : 1'b0;
            f_done = (who == 1) && req && s_ready;
            d_done = (who == 2) && req && s_ready;
            e.grant = 2'(who);
            e.mv    = req;
            if (who == 1) e.addr = if_addr;
            if (who == 2) begin
                e.addr  = d_addr;
                e.wdata = d_wdata;
                e.wstrb = d_wstrb;
            end
            e.ifr = f_done;
            e.dr  = d_done;
            if (f_done) q_if.push_back(s_rdata);
            if (d_done) q_d.push_back(s_rdata);
            m_holder = (req && !s_ready) ? who : 0;
            if (d_done && if_valid) m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
            else if (f_done || !if_valid) m_starve = 0;
            pend_if = if_valid && !f_done;
            pend_d  = d_valid && !d_done;
        end
        q_cyc.push_back(e);
    endtask

    // Monitor: score every cycle's port state and every delivered response.
    always @(negedge clk) begin
        cyc_t e;
        if (q_cyc.size() > 0) begin
            e = q_cyc.pop_front();
            chk("m_valid", 32'(m_valid), 32'(e.mv));
            chk("grant",   32'(grant),   32'(e.grant));
            chk("if_ready", 32'(if_ready), 32'(e.ifr));
            chk("d_ready",  32'(d_ready),  32'(e.dr));
            if (e.mv) begin
                chk("m_addr",  m_addr,         e.addr);
                chk("m_wdata", m_wdata,        e.wdata);
                chk("m_wstrb", 32'(m_wstrb),   32'(e.wstrb));
            end
            if (if_ready) begin
                chk("if_resp_expected", 32'(q_if.size() > 0), 32'd1);
                if (q_if.size() > 0) chk("if_rdata", if_rdata, q_if.pop_front());
            end
            if (d_ready) begin
                chk("d_resp_expected", 32'(q_d.size() > 0), 32'd1);
                if (q_d.size() > 0) chk("d_rdata", d_rdata, q_d.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1; if_valid = 1'b0; if_addr = '0; d_valid = 1'b0;
        d_addr = '0; d_wdata = '0; d_wstrb = '0; s_ready = 1'b0; s_rdata = '0;
        // reset, with requests present to confirm output gating
        for (int i = 0; i < 3; i++) step(1'b1, 100, 100, 100, 100);
        // fetch-only streaming at full throughput
        for (int i = 0; i < 20; i++) step(1'b0, 100, 0, 100, 100);
        // both masters saturated: data priority then starvation relief
        for (int i = 0; i < 40; i++) step(1'b0, 100, 100, 100, 100);
        // slow memory: locks, late requests, abandoned requests
        for (int i = 0; i < 300; i++) step(1'b0, 70, 70, 30, 85);
        // heavy contention, mostly-ready memory
        for (int i = 0; i < 300; i++) step(1'b0, 90, 90, 80, 95);
        // mixed traffic with occasional reset pulses, including mid-lock
        for (int i = 0; i < 600; i++)
            step($urandom_range(99) < 3, 60, 60, 50, 85);
        step(1'b0, 0, 0, 100, 0);
        step(1'b0, 0, 0, 100, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("if_resp_queue_drained", q_if.size(), 0);
        chk("d_resp_queue_drained",  q_d.size(),  0);
        chk("cycle_queue_drained",   q_cyc.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares a single memory port (valid/ready, single-cycle-response slave) between the instruction-fetch master and the load/store master.
- Data side has priority, guarded by a starvation counter so fetch always makes progress.
- Routing is combinational (zero added latency); the grant is locked in registers while a granted request waits for slave ready.
- Sits between the pipeline's fetch and LSU stages and the unified memory.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width; strobe width is DATA_W/8
STARVE_LIMIT, 4, consecutive data handshakes allowed while fetch waits before fetch wins (must be >= 1)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
i_if_valid  in  1  fetch request
i_if_addr  in  ADDR_W  fetch address
o_if_ready  out  1  fetch handshake complete this cycle
o_if_rdata  out  DATA_W  fetch read data (valid when o_if_ready)
i_d_valid  in  1  LSU request
i_d_addr  in  ADDR_W  LSU address
i_d_wdata  in  DATA_W  LSU write data
i_d_wstrb  in  DATA_W/8  LSU byte strobes (0 = read)
o_d_ready  out  1  LSU handshake complete this cycle
o_d_rdata  out  DATA_W  LSU read data (valid when o_d_ready)
o_m_valid  out  1  request to memory
o_m_addr  out  ADDR_W  memory address
o_m_wdata  out  DATA_W  memory write data
o_m_wstrb  out  DATA_W/8  memory strobes
i_s_ready  in  1  memory accepts/completes request this cycle
i_s_rdata  in  DATA_W  memory read data, same cycle as i_s_ready
o_grant  out  2  current routed owner: 00 none, 01 fetch, 10 data

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- State owner_q ∈ {NONE, IF, DATA}; starve_q is $clog2(STARVE_LIMIT+1) bits wide. Reset: owner_q=NONE, starve_q=0.
- While rst=1: o_m_valid=0, o_if_ready=0, o_d_ready=0, o_grant=00. Other outputs don't-care but driven (0).
- Selection in NONE (combinational):
  - DATA if i_d_valid && (starve_q<STARVE_LIMIT || !i_if_valid).
  - else IF if i_if_valid.
  - else none.
- In IF/DATA: selection = owner_q, no re-arbitration.
- Routing:
  - o_m_valid = selected master's valid.
  - o_m_addr = selected addr.
  - DATA: wdata/wstrb from LSU. IF or none: wdata=0, wstrb=0.
  - When no master is selected, o_m_addr=0.
- Responses:
  - o_if_ready = (sel==IF) && i_if_valid && i_s_ready.
  - o_d_ready likewise for DATA.
  - o_if_rdata = o_d_rdata = i_s_rdata (broadcast); qualify with the ready signals.
- Next-state:
  - Handshake completes (o_m_valid && i_s_ready): owner_q <= NONE.
  - Selected valid high && !i_s_ready: owner_q <= selected (lock).
  - Locked owner drops its valid (e.g. fetch flush/stall): o_m_valid=0 that cycle, owner_q <= NONE. The request is abandoned, with no response.
  - Otherwise owner_q <= NONE.
- Starvation counter (updated at clock edge):
  - Completed data handshake while i_if_valid=1: starve_q <= min(starve_q+1, STARVE_LIMIT).
  - Completed fetch handshake, or i_if_valid=0: starve_q <= 0.
  - Else hold.
- Simultaneous requests from NONE with starve_q<LIMIT: data wins; fetch waits with o_if_ready=0.
- Once starve_q==LIMIT and both valid: fetch wins the next arbitration, and its completion clears starve_q.
- A new request from the same master in the cycle after a completion is arbitrated normally; back-to-back throughput is one handshake per cycle when i_s_ready=1.
- Reset asserted mid-lock: owner_q returns to NONE next edge and outputs are gated during reset; no response is delivered.
- Address, data and strobe stability while locked is the requester's responsibility; the arbiter routes inputs combinationally.

Test Plan:
- Fetch only, i_if_addr=0x0,0x4,0x8, i_s_ready=1 each cycle -> o_if_ready=1 three consecutive cycles, o_m_wstrb=0, o_grant=01, rdata passed through.
- Both valid, d write addr 0x100 wstrb=0xF, s_ready=1 -> cycle 0 o_grant=10, o_d_ready=1, o_if_ready=0; starve_q=1.
- Both valid continuously, STARVE_LIMIT=4, s_ready=1 -> 4 data handshakes, then fetch handshake on cycle 4, starve_q back to 0, then data again.
- Fetch selected, s_ready=0 for 3 cycles while i_d_valid rises -> o_grant stays 01, o_d_ready=0. s_ready=1 on cycle 3 -> o_if_ready=1, data granted cycle 4.
- Fetch locked with s_ready=0, then i_if_valid drops -> o_m_valid=0 that cycle, owner NONE next cycle, pending LSU granted.
- rst=1 asserted during a locked data request -> o_m_valid=0 and readys 0 during reset; after release, o_grant=00 and starve_q=0.
